// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the round-robin register-bank write controller.
package regbank_pkg;

  localparam int N_REQ_DEF  = 4;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  // Upper bound on requester count; sizes the one-hot helper result.
  localparam int MAX_REQ = 8;

  // Width of a requester index for a given requester count.
  localparam int GNT_ID_W_DEF = $clog2(N_REQ_DEF);

  // One-hot vector with bit idx set; callers truncate to their requester count.
  function automatic logic [MAX_REQ-1:0] onehot_of(input int unsigned idx);
    onehot_of = MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/regbank_rr_wr_ctrl_arbiter.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr wins.
module rr_arbiter
  import regbank_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_elig,
  input  logic [IDW-1:0]   i_ptr,
  output logic             o_win_valid,
  output logic [IDW-1:0]   o_win_idx
);

  int w_idx;

  // Scan ptr, ptr+1, ... with wrap; keep the first hit.
  always_comb begin
    o_win_valid = 1'b0;
    o_win_idx   = '0;
    w_idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(i_ptr) + k) % N_REQ;
      if (!o_win_valid && i_elig[w_idx]) begin
        o_win_valid = 1'b1;
        o_win_idx   = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/regbank_rr_wr_ctrl.sv
// Register bank with round-robin arbitrated single-write-per-cycle port and
// combinational read port. Optional even-parity storage and read-side parity
// check is enabled by defining REGBANK_PARITY_EN.
module regbank_rr_wr_ctrl
  import regbank_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int IDW   = $clog2(N_REQ),
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic [IDW-1:0]           gnt_id,
  output logic                     busy,
  input  logic [ADDR_W-1:0]        rd_addr,
`ifdef REGBANK_PARITY_EN
  output logic                     rd_par_err,
`endif
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] r_bank [DEPTH];
  logic [N_REQ-1:0]  r_gnt;
  logic [IDW-1:0]    r_gnt_id;
  logic              r_busy;
  logic [IDW-1:0]    r_ptr;

  logic [ADDR_W-1:0] w_addr [N_REQ];
  logic [DATA_W-1:0] w_data [N_REQ];
  logic [N_REQ-1:0]  w_elig;
  logic              w_win_valid;
  logic [IDW-1:0]    w_win_idx;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [N_REQ-1:0]  w_gnt_nxt;
  logic [IDW-1:0]    w_ptr_nxt;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_addr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_data[g] = req_data[g*DATA_W +: DATA_W];
  end

  // A requester granted last cycle sits out one cycle so others get a turn.
  assign w_elig = req & ~r_gnt;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_elig      (w_elig),
    .i_ptr       (r_ptr),
    .o_win_valid (w_win_valid),
    .o_win_idx   (w_win_idx)
  );

  assign w_wr_addr = w_addr[w_win_idx];
  assign w_wr_data = w_data[w_win_idx];
  assign w_gnt_nxt = w_win_valid ? N_REQ'(onehot_of(32'(w_win_idx))) : '0;
  assign w_ptr_nxt = (w_win_idx == IDW'(N_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  // Grant, grant index, busy flag and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_busy   <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_gnt  <= w_gnt_nxt;
      r_busy <= w_win_valid;
      if (w_win_valid) begin
        r_gnt_id <= w_win_idx;
        r_ptr    <= w_ptr_nxt;
      end
    end
  end

  // Bank storage: commit the winning requester's write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) r_bank[a] <= '0;
    end else if (w_win_valid) begin
      r_bank[w_wr_addr] <= w_wr_data;
    end
  end

`ifdef REGBANK_PARITY_EN
  logic r_par [DEPTH];

  // Even parity per entry so data plus parity always XORs to zero when intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < DEPTH; a++) r_par[a] <= 1'b0;
    end else if (w_win_valid) begin
      r_par[w_wr_addr] <= ^w_wr_data;
    end
  end

  assign rd_par_err = ^{r_bank[rd_addr], r_par[rd_addr]};
`endif

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign rd_data = r_bank[rd_addr];

endmodule

// File: tb/tb_regbank_rr_wr_ctrl.sv
// Self-checking bench for regbank_rr_wr_ctrl (N_REQ=4, DATA_W=8, ADDR_W=2).
// With REGBANK_PARITY_EN defined, the parity output is checked as well.
module tb_regbank_rr_wr_ctrl;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_id;
  logic          busy;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
`ifdef REGBANK_PARITY_EN
  logic          rd_par_err;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b1;

  // Reference model state (plain integers / arrays).
  int m_bank [D] = '{0, 0, 0, 0};
  int m_ptr  = 0;
  int m_last = -1;
  int m_gnt  = 0;
  int m_id   = 0;
  int m_busy = 0;

  regbank_rr_wr_ctrl #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .req_data (req_data),
    .gnt      (gnt),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .rd_addr  (rd_addr),
`ifdef REGBANK_PARITY_EN
    .rd_par_err (rd_par_err),
`endif
    .rd_data  (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input int a, input int d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*DW +: DW] = DW'(d);
  endtask

  // Model: on each edge, the first requester at or after the pointer that
  // asks and was not granted last cycle wins and writes its data.
  always @(posedge clk) begin
    int w;
    if (!rst_n) begin
      for (int a = 0; a < D; a++) m_bank[a] = 0;
      m_ptr = 0; m_last = -1; m_gnt = 0; m_id = 0; m_busy = 0;
    end else begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (w < 0 && req[i] && i != m_last) w = i;
      end
      if (w >= 0) begin
        m_bank[req_addr[w*AW +: AW]] = int'(req_data[w*DW +: DW]);
        m_last = w; m_gnt = 1 << w; m_id = w;
        m_ptr = (w + 1) % N; m_busy = 1;
      end else begin
        m_last = -1; m_gnt = 0; m_busy = 0;
      end
    end
    #1;
    if (mon_en) begin
      check("gnt", int'(gnt), m_gnt);
      if (m_gnt != 0) check("gnt_id", int'(gnt_id), m_id);
      check("busy", int'(busy), m_busy);
      check("rd_data", int'(rd_data), m_bank[rd_addr]);
`ifdef REGBANK_PARITY_EN
      check("rd_par_err", int'(rd_par_err), 0);
`endif
    end
  end

  initial begin
    // Reset and reset-value checks.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gnt_id", int'(gnt_id), 0);
    for (int a = 0; a < D; a++) begin
      rd_addr = AW'(a); #1;
      check("rst_rd", int'(rd_data), 0);
    end

    // Single requester, held request re-granted every second cycle.
    set_req(2, 1, 8'hA5);
    req = 4'b0100;
    @(negedge clk);
    check("single_gnt", int'(gnt), 4'b0100);
    check("single_id", int'(gnt_id), 2);
    check("single_busy", int'(busy), 1);
    rd_addr = 2'd1; #1;
    check("single_rd", int'(rd_data), 8'hA5);
    @(negedge clk);
    check("single_gap_gnt", int'(gnt), 0);
    check("single_gap_busy", int'(busy), 0);
    @(negedge clk);
    check("single_regnt", int'(gnt), 4'b0100);

    // Pointer at 3 after granting 2: requesters 3 and 0 alternate.
    set_req(0, 0, 8'h3C);
    set_req(3, 2, 8'hC3);
    req = 4'b1001;
    @(negedge clk);
    check("wrap_gnt3", int'(gnt), 4'b1000);
    check("wrap_busy3", int'(busy), 1);
    @(negedge clk);
    check("wrap_gnt0", int'(gnt), 4'b0001);
    check("wrap_busy0", int'(busy), 1);
    req = 4'b0000;
    @(negedge clk);
    check("wrap_idle_gnt", int'(gnt), 0);
    check("wrap_idle_busy", int'(busy), 0);
    rd_addr = 2'd2; #1;
    check("wrap_rd2", int'(rd_data), 8'hC3);
    rd_addr = 2'd0; #1;
    check("wrap_rd0", int'(rd_data), 8'h3C);

    // Mid-cycle reset with full contention pending.
    for (int i = 0; i < N; i++) set_req(i, i, 8'h50 + i);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_gnt", int'(gnt), 0);
    check("midrst_busy", int'(busy), 0);
    for (int a = 0; a < D; a++) begin
      rd_addr = AW'(a); #1;
      check("midrst_rd", int'(rd_data), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Full contention after release: 0,1,2,3,0.
    @(negedge clk);
    check("full_gnt_first", int'(gnt), 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("full_gnt_seq", int'(gnt), 1 << (k % 4));
    end
    req = 4'b0000;
    @(negedge clk);
    for (int a = 0; a < D; a++) begin
      rd_addr = AW'(a); #1;
      check("full_rd", int'(rd_data), 8'h50 + a);
    end

    // Same address from two requesters, pointer back at 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 3, 8'h11);
    set_req(1, 3, 8'h22);
    req = 4'b0011;
    rd_addr = 2'd3;
    @(negedge clk);
    check("same_gnt0", int'(gnt), 4'b0001);
    check("same_rd_first", int'(rd_data), 8'h11);
    req = 4'b0010;
    @(negedge clk);
    check("same_gnt1", int'(gnt), 4'b0010);
    check("same_rd_second", int'(rd_data), 8'h22);
    req = 4'b0000;

    // Randomized traffic obeying the hold-until-grant handshake.
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (cyc == 300) begin
        rst_n = 1'b0;
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (gnt[i]) begin
            if ($urandom_range(0, 1) == 1) set_req(i, $urandom_range(0, D-1), $urandom_range(0, 255));
            else req[i] = 1'b0;
          end else if ($urandom_range(0, 15) == 0) begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          set_req(i, $urandom_range(0, D-1), $urandom_range(0, 255));
          req[i] = 1'b1;
        end
      end
      rd_addr = AW'($urandom_range(0, D-1));
    end
    req = '0;
    repeat (2) @(negedge clk);

`ifdef REGBANK_PARITY_EN
    set_req(0, 0, 8'h07);
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    rd_addr = 2'd0; #1;
    check("par_rd", int'(rd_data), 8'h07);
    check("par_ok", int'(rd_par_err), 0);
    mon_en = 1'b0;
    force dut.r_bank[0] = 8'h06;
    #1;
    check("par_err", int'(rd_par_err), 1);
    release dut.r_bank[0];
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_rr_wr_ctrl.md
Name: regbank_rr_wr_ctrl

Overview:
- Controller for a small bank of async-reset D-flop registers, shared by N_REQ write requesters.
- Arbitrates write requests round-robin and commits one write per cycle into the bank.
- Exposes a combinational read port.
- Sits between multiple config/datapath masters and the shared register storage; replaces ad-hoc direct flop writes.

Parameters:
- N_REQ, 4, number of write requesters (2..8).
- DATA_W, 8, register width in bits.
- ADDR_W, 2, address width; bank depth DEPTH = 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester write request, level.
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  in  N_REQ*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- gnt  out  N_REQ  registered one-hot grant; high for exactly one cycle after the write commits.
- gnt_id  out  $clog2(N_REQ)  index of the requester currently granted; valid while gnt != 0.
- busy  out  1  registered; high when any eligible request was pending at the last edge.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  combinational output, bank[rd_addr].

Behaviour:
- Reset (async on rst_n low, held while low):
  - All bank registers = 0.
  - gnt = 0, gnt_id = 0, busy = 0.
  - Priority pointer ptr = 0, so requester 0 has highest priority.
  - Outputs reach reset values immediately, not at the next edge.
- Eligibility:
  - Requester i is eligible when req[i]=1 and gnt[i]=0.
  - A requester cannot win two consecutive cycles.
  - Different requesters may win back-to-back.
- Arbitration is combinational over eligible requesters:
  - Search starts at ptr and proceeds ptr, ptr+1, ... wrapping mod N_REQ.
  - The first eligible requester wins (index w).
- At each rising edge with a winner w:
  - bank[req_addr[w]] <= req_data[w].
  - gnt <= one-hot(w); gnt_id <= w.
  - ptr <= (w+1) mod N_REQ.
  - busy <= 1.
- At each rising edge with no winner:
  - gnt <= 0; ptr unchanged; busy <= 0; bank unchanged.
- Latency and handshake:
  - Request to commit is 1 edge.
  - gnt[i] high in cycle N+1 means the write sampled in cycle N is committed.
  - The requester must hold req, addr and data stable until it sees gnt.
  - It may keep req high for a further write; that write is eligible the cycle after gnt drops.
- Same-address writes: multiple requesters targeting one address commit in grant order; the last granted value persists.
- Read:
  - rd_data = bank[rd_addr], with no read latency.
  - A write committed at edge E is visible on rd_data immediately after E.
  - No write-through bypass.
- Fairness: with all requesters continuously requesting, the grant sequence is 0,1,...,N_REQ-1,0,...; worst-case wait is N_REQ-1 cycles.
- Mid-operation reset: a pending request is dropped without commit, and gnt clears asynchronously. After release, arbitration resumes from ptr = 0 on the first edge.
- req dropped before grant: no write; no error reported.

Optional Feature:
- Macro: REGBANK_PARITY_EN.
- Defined:
  - Each bank entry stores an additional even-parity bit, computed from the write data at commit.
  - Extra output rd_par_err (1 bit, combinational) = XOR of bank[rd_addr] data and parity bits.
  - Parity bits reset to 0, consistent with zero data.
- Undefined: no parity storage and no rd_par_err port.

Decomposition:
- Package regbank_pkg:
  - default constants N_REQ_DEF, DATA_W_DEF, ADDR_W_DEF.
  - gnt_id width derived via $clog2.
  - helper function for one-hot from index.
- Sub-module rr_arbiter, purely combinational:
  - inputs: eligible vector, ptr.
  - outputs: win_valid, win_idx.
- The top holds ptr, gnt and bank flops.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req=4'b1111 pending -> gnt=0, busy=0, all rd_data=0 immediately; first grant after release goes to requester 0.
- Single requester: req[2]=1, addr=1, data=8'hA5 held -> gnt=4'b0100 one cycle later, rd_data@1=8'hA5; held req re-grants every second cycle.
- Full contention: req=4'b1111 continuously with distinct addresses -> gnt sequence 0001,0010,0100,1000,0001...; each address holds its requester's data.
- Pointer wrap: ptr=3 after granting 2, then req=4'b1001 -> grant 3 then 0; busy high throughout; busy drops 1 cycle after req=0.
- Same address: req0 data 8'h11 and req1 data 8'h22, both addr 3, simultaneous from ptr=0 -> bank[3]=8'h11 after first grant, 8'h22 after second.
- REGBANK_PARITY_EN: write 8'h07 -> rd_par_err=0; force a bit flip in the bank via the bench -> rd_par_err=1.
